// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: FSM states,
// requester IDs and the counter width helper.
package mem_arb_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Ceiling log2 for sizing counters; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry response holding register: load on grant, drain on rsp_ready.
// A load in the same cycle as a drain refills the slot without a bubble.
module mem_arb_rsp_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory read port 1 and the write port between
// the load/store unit (A) and the debug/loader port (B), with a boot hold-off.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int N_ELEMENTS  = 128,
    parameter int BOOT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    input  logic                  b_lock,

    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_w_en,

    output logic                  booting,
    output state_e                state_dbg
);

    // Handshake: a request transfers in any cycle where req_valid && req_ready;
    // a response transfers in any cycle where rsp_valid && rsp_ready. req_ready
    // is the combinational grant and depends on req_valid.

    localparam int CNT_W = (clog2(BOOT_CYCLES) < 1) ? 1 : clog2(BOOT_CYCLES);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(N_ELEMENTS);

    state_e                  state;
    logic [CNT_W-1:0]        boot_cnt;
    logic                    prio;

    logic                    a_elig;
    logic                    b_elig;
    logic                    grant_a;
    logic                    grant_b;
    logic                    grant_any;
    logic                    gnt_id;
    logic                    g_we;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic                    g_in_range;
    logic [DATA_WIDTH-1:0]   load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            boot_cnt <= '0;
            booting  <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == CNT_W'(BOOT_CYCLES - 1)) begin
                        state   <= RUN;
                        booting <= 1'b0;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state   <= BOOT;
                    booting <= 1'b1;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // A requester may only be granted if its response slot is free or draining.
    assign a_elig = a_req_valid & (~a_rsp_valid | a_rsp_ready);
    assign b_elig = b_req_valid & (~b_rsp_valid | b_rsp_ready);

    // Grants are masked in the rst cycle so a write there never reaches memory.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == RUN && !rst) begin
            if (b_lock) begin
                grant_b = b_elig;
            end else if (a_elig && b_elig) begin
                grant_a = (prio == REQ_A);
                grant_b = (prio == REQ_B);
            end else begin
                grant_a = a_elig;
                grant_b = b_elig;
            end
        end
    end

    assign grant_any   = grant_a | grant_b;
    assign gnt_id      = grant_b ? REQ_B : REQ_A;
    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ_A;
        end else if (grant_any) begin
            prio <= ~gnt_id;
        end
    end

    assign g_we       = grant_b ? b_req_we    : a_req_we;
    assign g_addr     = grant_b ? b_req_addr  : a_req_addr;
    assign g_wdata    = grant_b ? b_req_wdata : a_req_wdata;
    assign g_in_range = {1'b0, g_addr} < ADDR_LIMIT;

    // Out-of-range accesses are acknowledged but never touch memory.
    assign mem_w_en   = grant_any & g_we & g_in_range;
    assign mem_w_addr = (grant_any & g_we)  ? g_addr  : '0;
    assign mem_w_data = (grant_any & g_we)  ? g_wdata : '0;
    assign mem_r_addr = (grant_any & ~g_we) ? g_addr  : '0;
    assign load_data  = g_we ? g_wdata : (g_in_range ? mem_r_data : '0);

    mem_arb_rsp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_a),
        .load_data (load_data),
        .rsp_ready (a_rsp_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_data  (a_rsp_data)
    );

    mem_arb_rsp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_b),
        .load_data (load_data),
        .rsp_ready (b_rsp_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_data  (b_rsp_data)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory model on the DUT's memory ports, a
// monitor-driven scoreboard for responses, and directed scenarios.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NE = 128;

    logic          clk;
    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_we;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_rsp_valid, a_rsp_ready;
    logic [DW-1:0] a_rsp_data;
    logic          b_req_valid, b_req_ready, b_req_we;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_data;
    logic          b_lock;
    logic [AW-1:0] mem_r_addr;
    logic [DW-1:0] mem_r_data;
    logic [AW-1:0] mem_w_addr;
    logic [DW-1:0] mem_w_data;
    logic          mem_w_en;
    logic          booting;
    state_e        state_dbg;

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .N_ELEMENTS  (NE),
        .BOOT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_data  (a_rsp_data),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_data  (b_rsp_data),
        .b_lock      (b_lock),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (mem_r_data),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_w_en    (mem_w_en),
        .booting     (booting),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; out-of-range reads return a poison value.
    logic [DW-1:0] mem     [0:NE-1];
    logic [DW-1:0] ref_mem [0:NE-1];

    assign mem_r_data = (mem_r_addr < AW'(NE)) ? mem[mem_r_addr[6:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_w_en && (mem_w_addr < AW'(NE))) mem[mem_w_addr[6:0]] <= mem_w_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push on an observed grant; expected data comes from ref_mem.
    task automatic observe_grant(input bit is_b, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        logic [DW-1:0] e_val;
        logic          in_rng;
        in_rng = (32'(addr) < NE);
        if (we) begin
            e_val = wdata;
            check("grant_w_en", 32'(mem_w_en), 32'(in_rng));
            if (in_rng) begin
                ref_mem[addr[6:0]] = wdata;
                check("grant_w_addr", 32'(mem_w_addr), 32'(addr));
                check("grant_w_data", 32'(mem_w_data), 32'(wdata));
            end
        end else begin
            e_val = in_rng ? ref_mem[addr[6:0]] : '0;
            check("grant_r_addr", 32'(mem_r_addr), 32'(addr));
            check("grant_r_w_en", 32'(mem_w_en), 0);
        end
        if (is_b) exp_b.push_back(e_val);
        else      exp_a.push_back(e_val);
    endtask

    // Monitor: pops on response transfer, pushes on grant.
    always @(negedge clk) begin
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (a_rsp_valid && a_rsp_ready) begin
                if (exp_a.size() == 0) check("a_rsp_expected", 32'(exp_a.size()), 1);
                else check("a_rsp_data", 32'(a_rsp_data), 32'(exp_a.pop_front()));
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (exp_b.size() == 0) check("b_rsp_expected", 32'(exp_b.size()), 1);
                else check("b_rsp_data", 32'(b_rsp_data), 32'(exp_b.pop_front()));
            end
            check("single_grant", 32'(a_req_ready & b_req_ready), 0);
            if (a_req_valid && a_req_ready) begin
                observe_grant(1'b0, a_req_we, a_req_addr, a_req_wdata);
            end else if (b_req_valid && b_req_ready) begin
                observe_grant(1'b1, b_req_we, b_req_addr, b_req_wdata);
            end else begin
                check("idle_w_en", 32'(mem_w_en), 0);
                check("idle_r_addr", 32'(mem_r_addr), 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < NE; i++) begin
            mem[i]     = DW'(i * 37 + 256);
            ref_mem[i] = DW'(i * 37 + 256);
        end
        mem[7'h13]     = 16'h0005;
        ref_mem[7'h13] = 16'h0005;

        rst = 1'b1;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0013; a_req_wdata = '0;
        a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_rsp_ready = 1'b1;
        b_lock = 1'b0;

        // Reset state and boot window
        tick();
        @(negedge clk);
        check("rst_booting", 32'(booting), 1);
        check("rst_state", 32'(state_dbg), 32'(BOOT));
        check("rst_a_rsp_valid", 32'(a_rsp_valid), 0);
        check("rst_a_rsp_data", 32'(a_rsp_data), 0);
        check("rst_w_en", 32'(mem_w_en), 0);
        check("rst_r_addr", 32'(mem_r_addr), 0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("boot_a_ready", 32'(a_req_ready), 0);
            check("boot_booting", 32'(booting), 1);
            tick();
        end
        @(negedge clk);
        check("boot_grant", 32'(a_req_ready), 1);
        check("boot_done", 32'(booting), 0);
        check("run_state", 32'(state_dbg), 32'(RUN));
        check("lat_r_addr", 32'(mem_r_addr), 32'h13);
        tick();
        a_req_valid = 1'b0;
        @(negedge clk);
        check("lat_a_rsp_valid", 32'(a_rsp_valid), 1);
        check("lat_a_rsp_data", 32'(a_rsp_data), 32'h0005);
        tick();

        // Single B read so the next contested grant starts with A
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 16'h0021;
        @(negedge clk);
        check("b_solo_grant", 32'(b_req_ready), 1);
        tick();
        b_req_valid = 1'b0;
        @(negedge clk);
        check("b_solo_rsp_valid", 32'(b_rsp_valid), 1);
        tick();

        // Round robin with both requesting every cycle
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_req_addr = AW'(i + 2);
            b_req_addr = AW'(i + 40);
            @(negedge clk);
            check("rr_a_grant", 32'(a_req_ready), 32'((i % 2) == 0));
            check("rr_b_grant", 32'(b_req_ready), 32'((i % 2) == 1));
            check("rr_w_en", 32'(mem_w_en), 0);
            tick();
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        tick();

        // Lock with B backpressure
        b_lock = 1'b1;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0016; b_req_wdata = 16'h1234;
        b_rsp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0030; a_rsp_ready = 1'b1;
        @(negedge clk);
        check("lock_b_grant", 32'(b_req_ready), 1);
        check("lock_a_blocked", 32'(a_req_ready), 0);
        check("lock_w_en", 32'(mem_w_en), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_a_blocked", 32'(a_req_ready), 0);
            check("stall_b_blocked", 32'(b_req_ready), 0);
            check("stall_b_valid", 32'(b_rsp_valid), 1);
            check("stall_b_data", 32'(b_rsp_data), 32'h1234);
            tick();
        end
        b_req_valid = 1'b0; b_rsp_ready = 1'b1;
        @(negedge clk);
        check("lock_idle_a_blocked", 32'(a_req_ready), 0);
        tick();
        b_lock = 1'b0;
        @(negedge clk);
        check("unlock_a_grant", 32'(a_req_ready), 1);
        tick();
        a_req_valid = 1'b0;
        tick();

        // Read back the locked write
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 16'h0016;
        @(negedge clk);
        check("rb_grant", 32'(b_req_ready), 1);
        tick();
        b_req_valid = 1'b0;
        @(negedge clk);
        check("rb_data", 32'(b_rsp_data), 32'h1234);
        tick();

        // Out-of-range write then read
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0080; b_req_wdata = 16'hBEEF;
        @(negedge clk);
        check("oor_w_grant", 32'(b_req_ready), 1);
        check("oor_w_en", 32'(mem_w_en), 0);
        tick();
        b_req_we = 1'b0;
        @(negedge clk);
        check("oor_r_grant", 32'(b_req_ready), 1);
        check("oor_w_ack", 32'(b_rsp_data), 32'hBEEF);
        tick();
        b_req_valid = 1'b0;
        @(negedge clk);
        check("oor_r_data", 32'(b_rsp_data), 0);
        tick();

        // Reset mid-operation with a held response and a pending write
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0013; a_rsp_ready = 1'b0;
        @(negedge clk);
        check("mid_a_grant", 32'(a_req_ready), 1);
        tick();
        a_req_valid = 1'b0;
        @(negedge clk);
        check("mid_a_rsp_valid", 32'(a_rsp_valid), 1);
        tick();
        rst = 1'b1;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0005; b_req_wdata = 16'hAAAA;
        @(negedge clk);
        check("rstcyc_w_en", 32'(mem_w_en), 0);
        check("rstcyc_b_grant", 32'(b_req_ready), 0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("rerst_a_rsp_valid", 32'(a_rsp_valid), 0);
                check("rerst_state", 32'(state_dbg), 32'(BOOT));
                check("rerst_booting", 32'(booting), 1);
                check("rerst_mem_kept", 32'(mem[5]), 32'(ref_mem[5]));
            end
            check("reboot_b_blocked", 32'(b_req_ready), 0);
            tick();
        end
        @(negedge clk);
        check("reboot_b_grant", 32'(b_req_ready), 1);
        tick();
        b_req_valid = 1'b0;
        tick();
        tick();

        check("a_queue_empty", 32'(exp_a.size()), 0);
        check("b_queue_empty", 32'(exp_b.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
